// File: rtl/cave_player_input.sv
// Input conditioning between hps_io and Main: PS/2 key decode, joystick merge,
// SOCD cleaning, coin pulse stretching and pause toggling.
module cave_player_input #(
    parameter int COIN_HOLD = 4096
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [10:0] joystick_0,
    input  logic [10:0] joystick_1,
    output logic [9:0]  player1,
    output logic [9:0]  player2,
    output logic        pause
);
    localparam int CW = $clog2(COIN_HOLD);
    localparam logic [CW-1:0] COIN_RELOAD = CW'(COIN_HOLD - 1);

    typedef enum logic [4:0] {
        K_UP, K_DOWN, K_LEFT, K_RIGHT, K_CTRL, K_ALT, K_SPACE,
        K_1, K_2, K_5, K_6, K_9, K_0,
        K_A, K_S, K_Q, K_R, K_F, K_D, K_G, K_P,
        K_NONE
    } key_e;

    key_e        key_sel;
    logic [20:0] keys;
    logic        tog_q;
    logic        armed;
    logic        key_event;
    logic [9:0]  kb1, kb2;
    logic [9:0]  m_pl [2];
    logic        m_pause;
    logic [CW-1:0] coin_cnt [2];
    logic [1:0]  coin_prev;
    logic        pause_prev;
    logic [9:0]  pl_q [2];

    // Joystick layout {svc,pause,coin,start,b3,b2,b1,U,D,L,R} -> player layout.
    function automatic logic [9:0] joy_to_player(input logic [10:0] joy);
        return {joy[10], joy[8:4], joy[0], joy[1], joy[2], joy[3]};
    endfunction

    function automatic logic [3:0] socd_dir(input logic [3:0] dir);
        logic [3:0] v;
        v = dir;
        if (dir[1:0] == 2'b11) v[1:0] = 2'b00;
        if (dir[3:2] == 2'b11) v[3:2] = 2'b00;
        return v;
    endfunction

    always_comb begin
        // NOTE: default assigned first so unmapped codes can never infer a latch.
        key_sel = K_NONE;
        case (ps2_key[7:0])
            8'h75:   key_sel = K_UP;
            8'h72:   key_sel = K_DOWN;
            8'h6B:   key_sel = K_LEFT;
            8'h74:   key_sel = K_RIGHT;
            8'h14:   key_sel = K_CTRL;
            8'h11:   key_sel = K_ALT;
            8'h29:   key_sel = K_SPACE;
            8'h16:   key_sel = K_1;
            8'h1E:   key_sel = K_2;
            8'h2E:   key_sel = K_5;
            8'h36:   key_sel = K_6;
            8'h46:   key_sel = K_9;
            8'h45:   key_sel = K_0;
            8'h1C:   key_sel = K_A;
            8'h1B:   key_sel = K_S;
            8'h15:   key_sel = K_Q;
            8'h2D:   key_sel = K_R;
            8'h2B:   key_sel = K_F;
            8'h23:   key_sel = K_D;
            8'h34:   key_sel = K_G;
            8'h4D:   key_sel = K_P;
            default: key_sel = K_NONE;
        endcase
    end

    // The first clock after reset only samples the toggle, absorbing a stale level.
    assign key_event = armed && (ps2_key[10] != tog_q);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q <= 1'b0;
            armed <= 1'b0;
            keys  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            tog_q <= ps2_key[10];
            armed <= 1'b1;
            if (key_event && key_sel != K_NONE)
                keys[key_sel] <= ps2_key[9];
        end
    end

    assign kb1 = {keys[K_9], keys[K_5], keys[K_1], keys[K_SPACE], keys[K_ALT],
                  keys[K_CTRL], keys[K_RIGHT], keys[K_LEFT], keys[K_DOWN], keys[K_UP]};
    assign kb2 = {keys[K_0], keys[K_6], keys[K_2], keys[K_Q], keys[K_S],
                  keys[K_A], keys[K_G], keys[K_D], keys[K_F], keys[K_R]};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_pl[0] <= '0;
            m_pl[1] <= '0;
            m_pause <= 1'b0;
        end else begin
            m_pl[0] <= kb1 | joy_to_player(joystick_0);
            m_pl[1] <= kb2 | joy_to_player(joystick_1);
            m_pause <= keys[K_P] | joystick_0[9] | joystick_1[9];
        end
    end

    // A coin rising edge (re)loads the stretch counter; output holds while either is active.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                coin_cnt[p] <= '0;
                pl_q[p]     <= '0;
            end
            coin_prev  <= '0;
            pause_prev <= 1'b0;
            pause      <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                coin_prev[p] <= m_pl[p][8];
                if (m_pl[p][8] && !coin_prev[p])
                    coin_cnt[p] <= COIN_RELOAD;
                else if (coin_cnt[p] != '0)
                    coin_cnt[p] <= coin_cnt[p] - CW'(1);
                pl_q[p] <= {m_pl[p][9], m_pl[p][8] | (coin_cnt[p] != '0),
                            m_pl[p][7:4], socd_dir(m_pl[p][3:0])};
            end
            pause_prev <= m_pause;
            if (m_pause && !pause_prev)
                pause <= ~pause;
        end
    end

    assign player1 = pl_q[0];
    assign player2 = pl_q[1];

endmodule

// File: tb/tb_cave_player_input.sv
// Self-checking bench for cave_player_input: event-level model plus directed vectors.
module tb_cave_player_input;
    localparam int HOLD = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [10:0] joystick_0;
    logic [10:0] joystick_1;
    logic [9:0]  player1;
    logic [9:0]  player2;
    logic        pause;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    cave_player_input #(.COIN_HOLD(HOLD)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .player1    (player1),
        .player2    (player2),
        .pause      (pause)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Key codes per output bit (up,down,left,right,b1,b2,b3,start,coin,service).
    logic [7:0]  codes [2][10];
    int          jbit [10];
    bit [255:0]  kd;
    bit          armed_m, tog_m, mp;
    logic [9:0]  mm [2];
    int          rise [2];
    int          rises, e;
    logic [9:0]  exp_pl [2];
    logic        exp_pause;

    function automatic logic [9:0] model_stage1(input int p, input bit [255:0] k, input logic [10:0] j);
        logic [9:0] v;
        for (int i = 0; i < 10; i++) v[i] = k[codes[p][i]] | j[jbit[i]];
        return v;
    endfunction

    // age = stage-1 cycles since the last coin rising edge
    function automatic logic [9:0] model_out(input logic [9:0] m, input int age);
        logic [9:0] v;
        v = m;
        if (m[0] && m[1]) v[1:0] = 2'b00;
        if (m[2] && m[3]) v[3:2] = 2'b00;
        v[8] = m[8] || (age < HOLD);
        return v;
    endfunction

    task automatic model_reset();
        kd = '0; armed_m = 0; tog_m = 0; mp = 0;
        mm[0] = '0; mm[1] = '0;
        rise[0] = -1000; rise[1] = -1000;
        rises = 0; e = 0;
        exp_pl[0] = '0; exp_pl[1] = '0; exp_pause = 1'b0;
    endtask

    initial begin
        logic [9:0] nm [2];
        bit np;
        codes[0] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h46};
        codes[1] = '{8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36, 8'h45};
        jbit     = '{3, 2, 1, 0, 4, 5, 6, 7, 8, 10};
        model_reset();
        forever begin
            @(posedge clk_sys or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                e++;
                for (int p = 0; p < 2; p++) exp_pl[p] = model_out(mm[p], (e - 1) - rise[p]);
                exp_pause = (rises % 2) == 1;
                nm[0] = model_stage1(0, kd, joystick_0);
                nm[1] = model_stage1(1, kd, joystick_1);
                np = kd[8'h4D] | joystick_0[9] | joystick_1[9];
                for (int p = 0; p < 2; p++) if (nm[p][8] && !mm[p][8]) rise[p] = e;
                if (np && !mp) rises++;
                mm[0] = nm[0]; mm[1] = nm[1]; mp = np;
                if (armed_m && ps2_key[10] != tog_m) kd[ps2_key[7:0]] = ps2_key[9];
                tog_m = ps2_key[10];
                armed_m = 1;
            end
        end
    end

    initial begin
        wait (started);
        forever begin
            @(negedge clk_sys);
            check("cyc_player1", 32'(player1), 32'(exp_pl[0]));
            check("cyc_player2", 32'(player2), 32'(exp_pl[1]));
            check("cyc_pause", 32'(pause), 32'(exp_pause));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic key(input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    initial begin
        int hi, runs, toggles;
        logic prev;
        reset_n    = 1'b0;
        ps2_key    = {1'b1, 1'b1, 1'b0, 8'h75};
        joystick_0 = '0;
        joystick_1 = '0;
        tick(3);
        started = 1'b1;
        reset_n = 1'b1;

        // stale toggle level must not decode
        tick(4);
        check("rst_player1", 32'(player1), 32'd0);
        check("rst_player2", 32'(player2), 32'd0);
        check("rst_pause", 32'(pause), 32'd0);
        key(8'h75, 1'b1);
        tick(3);
        check("kb_up", 32'(player1), 32'h001);

        // SOCD with keyboard up + joystick down
        joystick_0[2] = 1'b1;
        tick(2);
        check("socd_ud", 32'(player1[1:0]), 32'd0);
        key(8'h75, 1'b0);
        tick(3);
        check("socd_release", 32'(player1[1:0]), 32'b10);
        joystick_0 = '0;
        tick(4);
        check("idle_player1", 32'(player1), 32'd0);

        // P2 coin: single-cycle pulse, then 20-cycle hold
        joystick_1[8] = 1'b1;
        hi = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_sys);
            if (i == 0) joystick_1[8] = 1'b0;
            if (player2[8]) hi++;
        end
        check("coin_pulse_len", 32'(hi), 32'd8);
        joystick_1[8] = 1'b1;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            if (i == 19) joystick_1[8] = 1'b0;
            if (player2[8]) hi++;
        end
        check("coin_held_len", 32'(hi), 32'd20);

        // P1 coin: second pulse 3 cycles after the first reloads the stretch
        joystick_0[8] = 1'b1;
        hi = 0; runs = 0; prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_sys);
            if (i == 0) joystick_0[8] = 1'b0;
            if (i == 2) joystick_0[8] = 1'b1;
            if (i == 3) joystick_0[8] = 1'b0;
            if (player1[8]) begin
                hi++;
                if (!prev) runs++;
            end
            prev = player1[8];
        end
        check("coin_reload_len", 32'(hi), 32'd11);
        check("coin_reload_runs", 32'(runs), 32'd1);

        // pause via key p
        key(8'h4D, 1'b1);
        tick(3);
        check("pause_press1", 32'(pause), 32'd1);
        key(8'h4D, 1'b0);
        tick(3);
        check("pause_release1", 32'(pause), 32'd1);
        key(8'h4D, 1'b1);
        tick(3);
        check("pause_press2", 32'(pause), 32'd0);
        key(8'h4D, 1'b0);
        tick(3);

        // pause held on joystick toggles once
        joystick_0[9] = 1'b1;
        toggles = 0;
        prev = pause;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk_sys);
            if (i == 99) joystick_0[9] = 1'b0;
            if (pause !== prev) toggles++;
            prev = pause;
        end
        check("pause_hold_toggles", 32'(toggles), 32'd1);
        check("pause_hold_level", 32'(pause), 32'd1);

        // async reset during a coin stretch with pause set
        joystick_0[8] = 1'b1;
        tick(1);
        joystick_0[8] = 1'b0;
        tick(3);
        check("stretch_active", 32'(player1[8]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_player1", 32'(player1), 32'd0);
        check("async_rst_player2", 32'(player2), 32'd0);
        check("async_rst_pause", 32'(pause), 32'd0);
        tick(2);
        reset_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (player1[8]) hi++;
        end
        check("no_spurious_coin", 32'(hi), 32'd0);
        check("post_rst_pause", 32'(pause), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
